// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner and its framebuffer.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } scanState_e;

  // Wide enough for any practical column count; modules slice what they need.
  localparam logic [31:0] COL_OFF = 32'hFFFF_FFFF;

  function automatic int unsigned slot_len(input int unsigned blank,
                                           input int unsigned sub,
                                           input int unsigned brtW);
    return blank + sub * (32'd1 << brtW);
  endfunction

endpackage

// File: rtl/led_matrix_scan_fb.sv
// Double-buffered row framebuffer: write port into the back bank, swap
// handshake, and combinational read of the displayed (front) bank.
module led_fb_dbuf
  import led_matrix_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iWe,
  input  logic [$clog2(ROWS)-1:0]  iWrRow,
  input  logic [COLS-1:0]          iWrData,
  input  logic                     iSwap,
  input  logic                     iSwapWindow,
  input  logic [$clog2(ROWS)-1:0]  iRdRow,
  output logic [COLS-1:0]          oRdData,
  output logic                     oSwapDone
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W:0] ROWS_CMP = (ROW_W+1)'(ROWS);

  logic [COLS-1:0] bankMem [2][ROWS];
  logic            frontSel;
  logic            pendQ;
  logic            pendEff;
  logic            swapAccept;
  logic            wrValid;

  // A request arriving on the window cycle itself is honoured immediately.
  assign pendEff    = pendQ | iSwap;
  assign swapAccept = pendEff & iSwapWindow;
  assign wrValid    = iWe & ({1'b0, iWrRow} < ROWS_CMP);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        bankMem[0][r] <= '0;
        bankMem[1][r] <= '0;
      end
    end else if (wrValid) begin
      // Uses the pre-swap select, so a same-edge write lands in the old back bank.
      bankMem[~frontSel][iWrRow] <= iWrData;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      frontSel  <= 1'b0;
      pendQ     <= 1'b0;
      oSwapDone <= 1'b0;
    end else begin
      frontSel  <= frontSel ^ swapAccept;
      pendQ     <= pendEff & ~swapAccept;
      oSwapDone <= swapAccept;
    end
  end

  assign oRdData = bankMem[frontSel][iRdRow];

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanned LED matrix driver with per-row blanking and global PWM brightness.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | scan disabled, outputs dark, swaps accepted every cycle
//   ST_BLANK  | row slot lead-in, all rows and columns off
//   ST_ACTIVE | current row driven, columns gated by PWM step < brightness
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int BLANK = 2,
  parameter int BRT_W = 2,
  parameter int SUB   = 1
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iEn,
  input  logic [BRT_W-1:0]         iBright,
  input  logic                     iWe,
  input  logic [$clog2(ROWS)-1:0]  iWrRow,
  input  logic [COLS-1:0]          iWrData,
  input  logic                     iSwap,
  output logic [ROWS-1:0]          oRow,
  output logic [COLS-1:0]          oCol,
  output logic                     oFrameStart,
  output logic                     oSwapDone
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int SUB_W  = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int SLOT   = int'(slot_len(BLANK, SUB, BRT_W));
  localparam int SLOT_W = $clog2(SLOT);

  localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(SLOT - 1);
  localparam logic [SLOT_W-1:0] BLANK_TC  = SLOT_W'(SLOT - BLANK);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COLS-1:0]   COL_DARK  = COL_OFF[COLS-1:0];

  scanState_e        state, stateNext;
  logic [ROW_W-1:0]  row, rowNext;
  logic [BRT_W-1:0]  step, stepNext;
  logic [SUB_W-1:0]  sub, subNext;
  logic [SLOT_W-1:0] slotCnt, slotNext;
  logic [BRT_W-1:0]  brightQ, brightNext;
  logic              frameStartNext;
  logic              frameBoundary;
  logic              swapWindow;
  logic [COLS-1:0]   frontRow;
  logic [ROWS-1:0]   rowOneHot;

  led_fb_dbuf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) uFb (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iWe         (iWe),
    .iWrRow      (iWrRow),
    .iWrData     (iWrData),
    .iSwap       (iSwap),
    .iSwapWindow (swapWindow),
    .iRdRow      (row),
    .oRdData     (frontRow),
    .oSwapDone   (oSwapDone)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= ST_IDLE;
      row     <= '0;
      step    <= '0;
      sub     <= '0;
      slotCnt <= '0;
      brightQ <= '0;
    end else begin
      state   <= stateNext;
      row     <= rowNext;
      step    <= stepNext;
      sub     <= subNext;
      slotCnt <= slotNext;
      brightQ <= brightNext;
    end
  end

  // slotCnt is a single down-counter spanning the whole row slot; BLANK_TC
  // marks the last blank cycle and zero marks the last PWM cycle.
  always_comb begin
    stateNext      = state;
    rowNext        = row;
    stepNext       = step;
    subNext        = sub;
    slotNext       = slotCnt;
    brightNext     = brightQ;
    frameStartNext = 1'b0;
    frameBoundary  = 1'b0;
    if (!iEn) begin
      stateNext = ST_IDLE;
      rowNext   = '0;
      stepNext  = '0;
      subNext   = '0;
      slotNext  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          stateNext      = ST_BLANK;
          rowNext        = '0;
          slotNext       = SLOT_LOAD;
          brightNext     = iBright;
          frameStartNext = 1'b1;
        end
        ST_BLANK: begin
          slotNext = slotCnt - SLOT_W'(1);
          if (slotCnt == BLANK_TC) begin
            stateNext = ST_ACTIVE;
            stepNext  = '0;
            subNext   = '0;
          end
        end
        ST_ACTIVE: begin
          slotNext = slotCnt - SLOT_W'(1);
          if (sub == SUB_LAST) begin
            subNext  = '0;
            stepNext = step + BRT_W'(1);
          end else begin
            subNext = sub + SUB_W'(1);
          end
          if (slotCnt == '0) begin
            stateNext = ST_BLANK;
            slotNext  = SLOT_LOAD;
            stepNext  = '0;
            subNext   = '0;
            if (row == ROW_LAST) begin
              rowNext        = '0;
              brightNext     = iBright;
              frameStartNext = 1'b1;
              frameBoundary  = 1'b1;
            end else begin
              rowNext = row + ROW_W'(1);
            end
          end
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  assign swapWindow = (state == ST_IDLE) | frameBoundary;
  assign rowOneHot  = ROWS'(1) << row;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRow        <= '0;
      oCol        <= COL_DARK;
      oFrameStart <= 1'b0;
    end else begin
      oRow        <= (state == ST_ACTIVE) ? rowOneHot : '0;
      oCol        <= ((state == ST_ACTIVE) && (step < brightQ)) ? ~frontRow : COL_DARK;
      oFrameStart <= frameStartNext;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Randomized scoreboard bench: a frame-position model predicts every output cycle.
module tb_led_matrix_scan;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int BLANK = 2;
  localparam int BRT_W = 2;
  localparam int SUB   = 1;
  localparam int SLOT  = BLANK + SUB * (1 << BRT_W);
  localparam int FRAME = ROWS * SLOT;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iEn = 1'b0;
  logic [BRT_W-1:0] iBright = '0;
  logic             iWe = 1'b0;
  logic [2:0]       iWrRow = '0;
  logic [COLS-1:0]  iWrData = '0;
  logic             iSwap = 1'b0;
  logic [ROWS-1:0]  oRow;
  logic [COLS-1:0]  oCol;
  logic             oFrameStart;
  logic             oSwapDone;

  led_matrix_scan #(
    .ROWS (ROWS), .COLS (COLS), .BLANK (BLANK), .BRT_W (BRT_W), .SUB (SUB)
  ) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iEn         (iEn),
    .iBright     (iBright),
    .iWe         (iWe),
    .iWrRow      (iWrRow),
    .iWrData     (iWrData),
    .iSwap       (iSwap),
    .oRow        (oRow),
    .oCol        (oCol),
    .oFrameStart (oFrameStart),
    .oSwapDone   (oSwapDone)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic            fs;
    logic            sd;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: scan position within the frame plus the two banks.
  bit              mRun;
  int              mPos;
  int              mBright;
  bit              mFront;
  bit              mPend;
  logic [COLS-1:0] mBuf [2][ROWS];

  task automatic modelReset();
    mRun = 0; mPos = 0; mBright = 0; mFront = 0; mPend = 0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++) mBuf[b][r] = '0;
  endtask

  // Called between edges with inputs stable; queues what follows the next edge.
  task automatic modelEdge();
    exp_t e;
    int   r, q, stp;
    bit   bnd, pendEff, acc;
    e.row = '0; e.col = '1; e.fs = 1'b0; e.sd = 1'b0;
    if (!iRst_n) begin
      modelReset();
      expQ.push_back(e);
      return;
    end
    if (mRun) begin
      r = mPos / SLOT;
      q = mPos % SLOT;
      if (q >= BLANK) begin
        stp   = (q - BLANK) / SUB;
        e.row = ROWS'(1 << r);
        if (stp < mBright) e.col = ~mBuf[mFront][r];
      end
    end
    bnd     = mRun && iEn && (mPos == FRAME - 1);
    pendEff = mPend || iSwap;
    acc     = pendEff && (!mRun || bnd);
    if (iWe && int'(iWrRow) < ROWS) mBuf[!mFront][iWrRow] = iWrData;
    if (acc) begin
      mFront = !mFront;
      mPend  = 0;
    end else begin
      mPend = pendEff;
    end
    e.sd = acc;
    if (!iEn) begin
      mRun = 0;
    end else if (!mRun) begin
      mRun = 1; mPos = 0; mBright = int'(iBright); e.fs = 1'b1;
    end else begin
      mPos = (mPos + 1) % FRAME;
      if (mPos == 0) begin
        mBright = int'(iBright);
        e.fs    = 1'b1;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic drive(input int n, input int enPct, input int swapPct,
                       input int wePct, input int brPct);
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      iRst_n  = 1'b1;
      iEn     = ($urandom_range(99) < enPct);
      iSwap   = ($urandom_range(99) < swapPct);
      iWe     = ($urandom_range(99) < wePct);
      iWrRow  = 3'($urandom_range(7));
      iWrData = COLS'($urandom);
      if ($urandom_range(99) < brPct) iBright = BRT_W'($urandom);
      modelEdge();
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      iRst_n = 1'b0;
      iEn = 1'b0; iSwap = 1'b0; iWe = 1'b0;
      if (i == 0) begin
        #1;
        total++;
        if (oRow !== '0 || oCol !== '1 || oFrameStart !== 1'b0 || oSwapDone !== 1'b0) begin
          bad++;
          $display("FAIL async_reset t=%0t got row=%b col=%b fs=%b sd=%b want row=0 col=all1 fs=0 sd=0",
                   $time, oRow, oCol, oFrameStart, oSwapDone);
        end
      end
      modelEdge();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge iClk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        total++;
        if ({oRow, oCol, oFrameStart, oSwapDone} !== e) begin
          bad++;
          $display("FAIL scan_out t=%0t row got %b want %b col got %b want %b fs got %b want %b sd got %b want %b",
                   $time, oRow, e.row, oCol, e.col, oFrameStart, e.fs, oSwapDone, e.sd);
        end
      end
    end
  end

  initial begin : stimulus
    doReset(3);
    iBright = 2'd3;
    drive(70, 100, 0, 0, 0);       // steady scan, dark framebuffer
    drive(600, 100, 2, 30, 3);     // writes, swaps, mid-frame brightness changes
    drive(600, 96, 5, 30, 5);      // frequent disable/re-enable with IDLE swaps
    drive(300, 100, 20, 20, 4);    // bursts of swap requests within a frame
    drive(47, 100, 3, 40, 2);      // leave the scan somewhere mid-row
    doReset(2);                    // asynchronous reset while scanning
    drive(400, 98, 4, 30, 4);      // displayed buffer must restart cleared
    @(posedge iClk);
    #2;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending expectations want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
- Parametrised, time-multiplexed driver for an ROWS x COLS LED matrix. A row is lit by driving it HIGH and a column by driving it LOW.
- Holds a double-buffered framebuffer. Scans one row at a time with a blanking gap before each row, and applies global PWM brightness.
- Sits between the pixel-writing logic (pattern generator or CPU bus) and the matrix pins. Successor to the passive 5x5 row/column status capture.

Parameters:
- ROWS, 5, number of row pins (>=2)
- COLS, 5, number of column pins (>=1)
- BLANK, 2, blanking cycles at the start of each row slot (>=1)
- BRT_W, 2, brightness width; 2^BRT_W PWM steps per row
- SUB, 1, clock cycles per PWM step (>=1)

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous, active-low reset
- iEn  in  1  scan enable
- iBright  in  BRT_W  global brightness; 0 = dark
- iWe  in  1  back-buffer row write strobe
- iWrRow  in  clog2(ROWS)  row address for the write
- iWrData  in  COLS  pixel bits for that row; bit c=1 means pixel on
- iSwap  in  1  request a front/back buffer swap
- oRow  out  ROWS  row drive, one-hot active-high
- oCol  out  COLS  column drive, active-low
- oFrameStart  out  1  one-cycle pulse at the start of a frame
- oSwapDone  out  1  one-cycle pulse when a swap takes effect

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - oRow=0, oCol=all 1s, oFrameStart=0, oSwapDone=0.
  - Both buffers cleared, front select=0, swap pending=0.
  - FSM=IDLE, row index=0, step and sub counters=0, latched brightness=0.
- FSM states: IDLE, BLANK, ACTIVE.
  - IDLE: if iEn=1, go to BLANK with row=0 and pulse oFrameStart. Latch iBright into bright_q.
  - BLANK: oRow=0, oCol=all 1s for exactly BLANK cycles, then go to ACTIVE with step=0 and sub=0.
  - ACTIVE: sub counts 0..SUB-1. On wrap, step increments. After step 2^BRT_W-1 wraps, the row slot ends.
    - If row<ROWS-1: row+1, go to BLANK.
    - If row=ROWS-1: this is the frame boundary. Row=0, go to BLANK, pulse oFrameStart, re-latch bright_q.
  - iEn=0 in any state: go to IDLE next cycle. Counters clear; outputs blank on the following cycle.
- Row slot length = BLANK + SUB*2^BRT_W cycles. Frame length = ROWS × row slot length.
- Drive in ACTIVE:
  - oRow = one-hot(row).
  - When step < bright_q: oCol = ~front[row]. Otherwise oCol = all 1s.
  - bright_q=0 gives fully dark. The maximum duty is (2^BRT_W-1)/2^BRT_W.
- Output timing: oRow and oCol are registered with 1-cycle latency from the FSM state. oFrameStart and oSwapDone are registered pulses aligned with the first blank cycle of row 0.
- Brightness: iBright is sampled only at frame start. A mid-frame change never alters the current frame.
- Writes:
  - iWe writes iWrData to back[iWrRow] on the same edge. The write is visible only after a swap.
  - A write with iWrRow>=ROWS is ignored.
  - Writes are accepted in every state.
- Swap:
  - iSwap=1 sets pending.
  - At a frame boundary, or on any cycle in IDLE, a pending swap toggles front select, pulses oSwapDone and clears pending.
  - iSwap while pending is absorbed; only one swap occurs.
  - iSwap on the same cycle as the boundary is honoured at that boundary.
  - After a swap the new back buffer holds the old front contents; it is not cleared.
- Simultaneous iWe and swap on the same edge: the write targets the back buffer as selected before the swap.
- Never more than one row asserted. oRow is always 0 for the BLANK cycles between rows, so there is no ghosting.

Decomposition:
- Package led_matrix_pkg holds:
  - state enum (IDLE, BLANK, ACTIVE)
  - function slot_len(BLANK, SUB, BRT_W)
  - constant COL_OFF (all 1s) for blank drive
- Sub-module led_fb_dbuf: two ROWS x COLS register arrays, front select, write port, swap pending and swap-accept logic, combinational read of front[row].
- The top level holds the scan FSM, counters, PWM compare and output registers.

Test Plan:
1. Reset, then iEn=1, iBright=3, no writes → oFrameStart pulses every 30 cycles. oRow cycles 00001→00010→…→10000, each asserted 4 cycles after 2 blank cycles. oCol stays 11111.
2. Write row2=5'b10101, pulse iSwap, iBright=3 → oSwapDone at the next boundary. In row2 ACTIVE cycles of the next frame, oCol=01010 for steps 0-2 and 11111 for step 3.
3. iBright=1 mid-frame → current frame keeps the old duty. From the next oFrameStart, each row lights 1 of 4 steps. iBright=0 → fully dark from the following frame.
4. iSwap pulsed 3 times within one frame → exactly one oSwapDone, at the boundary. A write with iWrRow=6 leaves both buffers unchanged.
5. iEn=0 mid-row3 → oRow=0 and oCol=11111 within 2 cycles. iSwap while disabled → oSwapDone next cycle. Re-enable → restarts at row 0 with oFrameStart.
6. iRst_n low mid-ACTIVE → outputs blank immediately (asynchronously). After release, the displayed buffer is all zeros.
